// File: rtl/stopwatch_counter.sv
// Stopwatch BCD time-keeping core: counts 100 Hz tick edges into mm:ss.cc
// with a start/pause/lap/clear FSM.
//
// Ports:
//   clk                 system clock, shared with the tick divider
//   rst                 asynchronous reset, active low
//   tick_in             divider output, sampled as data; rising edges count
//   btn_start           one-cycle pulse: start/pause toggle
//   btn_lap             one-cycle pulse: lap freeze/release, clear when paused
//   run                 divider enable, high in RUN and LAP
//   cs_t..min_o         BCD display digits (tens/ones of cs, sec, min)
//   wrap                one-cycle pulse after the full-scale rollover
module stopwatch_counter #(
  parameter int CS_MAX  = 99,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       run,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic       wrap
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam logic [3:0] CS_T_MAX  = 4'(CS_MAX / 10);
  localparam logic [3:0] CS_O_MAX  = 4'(CS_MAX % 10);
  localparam logic [3:0] SEC_T_MAX = 4'(SEC_MAX / 10);
  localparam logic [3:0] SEC_O_MAX = 4'(SEC_MAX % 10);
  localparam logic [3:0] MIN_T_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_O_MAX = 4'(MIN_MAX % 10);

  // Digit order in the packed vectors:
  // [0] cs_o, [1] cs_t, [2] sec_o, [3] sec_t, [4] min_o, [5] min_t
  logic [5:0][3:0] live_q, live_d;
  logic [5:0][3:0] lap_q, lap_d;
  logic [5:0][3:0] inc;
  logic [5:0][3:0] disp;

  logic [1:0] state_q, state_d;
  logic       tick_d_q;
  logic       wrap_q, wrap_d;

  logic tick_pulse;
  logic counting;
  logic count_en;
  logic cap;
  logic clr;
  logic cs_top;
  logic sec_top;
  logic min_top;

  assign tick_pulse = tick_in & ~tick_d_q;

  // Counting looks only at the current state, so a tick coincident with
  // a button counts when leaving RUN/LAP and not when entering RUN.
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign count_en = tick_pulse & counting;

  assign cs_top  = (live_q[1] == CS_T_MAX)  && (live_q[0] == CS_O_MAX);
  assign sec_top = (live_q[3] == SEC_T_MAX) && (live_q[2] == SEC_O_MAX);
  assign min_top = (live_q[5] == MIN_T_MAX) && (live_q[4] == MIN_O_MAX);

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (btn_start) begin
          state_d = S_PAUSE;
        end else if (btn_lap) begin
          state_d = S_LAP;
          cap     = 1'b1;
        end
      end
      S_LAP: begin
        if (btn_start) begin
          state_d = S_PAUSE;
        end else if (btn_lap) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (btn_start) begin
          state_d = S_RUN;
        end else if (btn_lap) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-centisecond increment with the full BCD carry chain.
  always_comb begin
    inc = live_q;
    if (cs_top) begin
      inc[1] = 4'd0;
      inc[0] = 4'd0;
      if (sec_top) begin
        inc[3] = 4'd0;
        inc[2] = 4'd0;
        if (min_top) begin
          inc[5] = 4'd0;
          inc[4] = 4'd0;
        end else if (live_q[4] == 4'd9) begin
          inc[4] = 4'd0;
          inc[5] = live_q[5] + 4'd1;
        end else begin
          inc[4] = live_q[4] + 4'd1;
        end
      end else if (live_q[2] == 4'd9) begin
        inc[2] = 4'd0;
        inc[3] = live_q[3] + 4'd1;
      end else begin
        inc[2] = live_q[2] + 4'd1;
      end
    end else if (live_q[0] == 4'd9) begin
      inc[0] = 4'd0;
      inc[1] = live_q[1] + 4'd1;
    end else begin
      inc[0] = live_q[0] + 4'd1;
    end
  end

  always_comb begin
    live_d = live_q;
    if (clr) begin
      live_d = '0;
    end else if (count_en) begin
      live_d = inc;
    end
  end

  // Lap captures the pre-increment value even if a tick lands this cycle.
  always_comb begin
    lap_d = lap_q;
    if (cap) lap_d = live_q;
  end

  assign wrap_d = count_en & cs_top & sec_top & min_top;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      live_q   <= '0;
      lap_q    <= '0;
      tick_d_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      lap_q    <= lap_d;
      tick_d_q <= tick_in;
      wrap_q   <= wrap_d;
    end
  end

  assign disp = (state_q == S_LAP) ? lap_q : live_q;

  assign cs_o  = disp[0];
  assign cs_t  = disp[1];
  assign sec_o = disp[2];
  assign sec_t = disp[3];
  assign min_o = disp[4];
  assign min_t = disp[5];

  assign run  = counting;
  assign wrap = wrap_q;

endmodule
